// File: rtl/r2mdc_stage_sequencer_pkg.sv
// Shared constants, pair-index type and stage-timing helpers for the 64-point R2MDC sequencer.
package r2mdc_pkg;
    localparam int NUM_INPUTS_PER_PATH = 32;
    localparam int CW                  = $clog2(NUM_INPUTS_PER_PATH);
    localparam int NUM_STAGES          = $clog2(2 * NUM_INPUTS_PER_PATH);
    localparam int NUM_CM              = NUM_STAGES - 1;

    typedef logic [CW-1:0] pair_idx_t;

    typedef struct packed {
        logic      vld;
        logic      sop;
        pair_idx_t cnt;
    } pipe_ent_t;

    function automatic int stage_delay(input int k);
        return NUM_INPUTS_PER_PATH >> (k + 1);
    endfunction

    function automatic int stage_offset(input int k, input int bf_latency);
        int ofs;
        ofs = 0;
        for (int j = 0; j <= k; j++) begin
            ofs += stage_delay(j) + bf_latency;
        end
        return ofs;
    endfunction

    function automatic pair_idx_t bit_reverse(input pair_idx_t v);
        pair_idx_t r;
        for (int i = 0; i < CW; i++) begin
            r[i] = v[CW-1-i];
        end
        return r;
    endfunction
endpackage

// File: rtl/r2mdc_stage_sequencer_if.sv
// Sequencer control bundle: input pair strobes in, stage timing and frame-aligned outputs out.
// out_idx exists only when R2MDC_BITREV_OUT_EN is defined.
interface r2mdc_stage_sequencer_if;
    import r2mdc_pkg::*;

    logic                     in_valid;
    logic                     in_sop;
    pair_idx_t                cntr_IFFT_input_pairs;
    logic [NUM_CM*CW-1:0]     stage_cnt;
    logic [NUM_CM-1:0]        cm_swap;
    logic [NUM_STAGES*CW-1:0] tw_addr;
    logic                     out_valid;
    logic                     out_sop;
    logic                     busy;
    logic                     err;
`ifdef R2MDC_BITREV_OUT_EN
    pair_idx_t                out_idx;
`endif

    modport master (
        output in_valid, in_sop,
        input  cntr_IFFT_input_pairs, stage_cnt, cm_swap, tw_addr,
        input  out_valid, out_sop, busy, err
`ifdef R2MDC_BITREV_OUT_EN
        , input out_idx
`endif
    );

    modport slave (
        input  in_valid, in_sop,
        output cntr_IFFT_input_pairs, stage_cnt, cm_swap, tw_addr,
        output out_valid, out_sop, busy, err
`ifdef R2MDC_BITREV_OUT_EN
        , output out_idx
`endif
    );
endinterface

// File: rtl/r2mdc_stage_sequencer_valid_pipe.sv
// Shift register of {valid, sop, count} with count taps at every commutator offset; latency = depth.
// Backpressure: none, advances every cycle.
module r2mdc_valid_pipe
    import r2mdc_pkg::*;
#(
    parameter int BF_LATENCY = 1
) (
    input  logic      CLK,
    input  logic      RSTN,
    input  pipe_ent_t din,
    output pair_idx_t tap_cnt [NUM_CM],
    output logic      out_vld,
    output logic      out_sop,
    output logic      any_vld
);
    localparam int DEPTH = stage_offset(NUM_CM - 1, BF_LATENCY) + BF_LATENCY;

    // sr[i] holds the entry sampled i+1 cycles ago
    pipe_ent_t sr [DEPTH];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    always_comb begin
        any_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_vld = any_vld | sr[i].vld;
        end
    end

    for (genvar k = 0; k < NUM_CM; k++) begin : g_tap
        assign tap_cnt[k] = sr[stage_offset(k, BF_LATENCY) - 1].cnt;
    end

    assign out_vld = sr[DEPTH-1].vld;
    assign out_sop = sr[DEPTH-1].sop;
endmodule

// File: rtl/r2mdc_stage_sequencer.sv
// R2MDC stage sequencer: frame counter, per-commutator count/swap, twiddle addresses; out latency 37 cycles.
// Backpressure: none (gaps abort the frame); R2MDC_BITREV_OUT_EN adds bit-reversed out_idx.
module r2mdc_stage_sequencer
    import r2mdc_pkg::*;
#(
    parameter int BF_LATENCY = 1
) (
    input logic                    CLK,
    input logic                    RSTN,
    r2mdc_stage_sequencer_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t    state;
    pair_idx_t cnt_q;
    logic      err_q;

    pair_idx_t pair_idx;
    logic      frame_vld;
    pipe_ent_t pipe_in;
    pair_idx_t cm_tap_cnt [NUM_CM];
    logic      pipe_out_vld;
    logic      pipe_out_sop;
    logic      pipe_busy;

    logic [NUM_CM*CW-1:0]     stage_cnt_w;
    logic [NUM_CM-1:0]        cm_swap_w;
    logic [NUM_STAGES*CW-1:0] tw_addr_w;

    // An sop pair is index 0 even when it restarts a frame in progress
    assign pair_idx  = (bus.in_valid && bus.in_sop) ? '0 : cnt_q;
    // Stray valids outside a frame carry no data and never reach the output
    assign frame_vld = bus.in_valid && (state == RUN || bus.in_sop);

    always_comb begin
        pipe_in     = '0;
        pipe_in.vld = frame_vld;
        pipe_in.sop = frame_vld && bus.in_sop;
        pipe_in.cnt = frame_vld ? pair_idx : '0;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_sop) begin
                        state <= RUN;
                        cnt_q <= pair_idx_t'(1);
                    end
                end
                RUN: begin
                    if (!bus.in_valid) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                        cnt_q <= '0;
                    end else if (bus.in_sop) begin
                        err_q <= 1'b1;
                        cnt_q <= pair_idx_t'(1);
                    end else if (cnt_q == pair_idx_t'(NUM_INPUTS_PER_PATH - 1)) begin
                        // IDLE accepts the next sop in the following cycle, so back-to-back frames see no gap
                        state <= IDLE;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + pair_idx_t'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    r2mdc_valid_pipe #(
        .BF_LATENCY (BF_LATENCY)
    ) u_valid_pipe (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .din     (pipe_in),
        .tap_cnt (cm_tap_cnt),
        .out_vld (pipe_out_vld),
        .out_sop (pipe_out_sop),
        .any_vld (pipe_busy)
    );

    // D_k = 2^(CW-1-k), so the swap select is bit CW-1-k of the local count
    always_comb begin
        stage_cnt_w      = '0;
        cm_swap_w        = '0;
        tw_addr_w        = '0;
        tw_addr_w[CW-1:0] = pair_idx;
        for (int k = 0; k < NUM_CM; k++) begin
            stage_cnt_w[k*CW +: CW]     = cm_tap_cnt[k];
            cm_swap_w[k]                = cm_tap_cnt[k][CW-1-k];
            tw_addr_w[(k+1)*CW +: CW]   = cm_tap_cnt[k] << (k + 1);
        end
    end

    assign bus.cntr_IFFT_input_pairs = pair_idx;
    assign bus.stage_cnt             = stage_cnt_w;
    assign bus.cm_swap               = cm_swap_w;
    assign bus.tw_addr               = tw_addr_w;
    assign bus.out_valid             = pipe_out_vld;
    assign bus.out_sop               = pipe_out_sop;
    assign bus.busy                  = (state == RUN) || pipe_busy;
    assign bus.err                   = err_q;

`ifdef R2MDC_BITREV_OUT_EN
    pair_idx_t out_cnt_q;
    pair_idx_t out_pos;

    assign out_pos = pipe_out_sop ? '0 : out_cnt_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            out_cnt_q <= '0;
        end else if (pipe_out_vld) begin
            out_cnt_q <= out_pos + pair_idx_t'(1);
        end
    end

    assign bus.out_idx = pipe_out_vld ? bit_reverse(out_pos) : '0;
`endif
endmodule

// File: tb/tb_r2mdc_stage_sequencer.sv
// Randomised and directed bench for r2mdc_stage_sequencer against a frame-level reference model.
module tb_r2mdc_stage_sequencer;
    localparam int N   = 32;
    localparam int NCM = 5;
    localparam int LAT = 37;

    logic CLK = 1'b0;
    logic RSTN;
    always #5 CLK = ~CLK;

    r2mdc_stage_sequencer_if bus();

    r2mdc_stage_sequencer #(.BF_LATENCY(1)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int ofs [NCM];
    int dk  [NCM];

    // Reference history: accepted pairs per cycle, ring-indexed by absolute cycle
    logic h_vld [64];
    logic h_sop [64];
    int   h_idx [64];
    int   cyc;
    int   m_next;
    logic m_err;

    logic [4:0]  o_cntr, e_cntr, o_sw, e_sw, o_idx, e_idx;
    logic [24:0] o_sc, e_sc;
    logic [29:0] o_tw, e_tw;
    logic        o_ov, e_ov, o_os, e_os, o_busy, e_busy, o_err, e_err;

    function automatic logic [73:0] obs_vec();
        return {o_cntr, o_sc, o_sw, o_tw, o_ov, o_os, o_busy, o_err, o_idx};
    endfunction

    function automatic logic [73:0] exp_vec();
        return {e_cntr, e_sc, e_sw, e_tw, e_ov, e_os, e_busy, e_err, e_idx};
    endfunction

    function automatic logic [4:0] bitrev5(input int v);
        int r;
        int x;
        r = 0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return 5'(r);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            h_vld[i] = 1'b0;
            h_sop[i] = 1'b0;
            h_idx[i] = 0;
        end
        m_next = 0;
        m_err  = 1'b0;
    endtask

    task automatic sample();
        o_cntr = bus.cntr_IFFT_input_pairs;
        o_sc   = bus.stage_cnt;
        o_sw   = bus.cm_swap;
        o_tw   = bus.tw_addr;
        o_ov   = bus.out_valid;
        o_os   = bus.out_sop;
        o_busy = bus.busy;
        o_err  = bus.err;
`ifdef R2MDC_BITREV_OUT_EN
        o_idx  = bus.out_idx;
`else
        o_idx  = 5'd0;
`endif
    endtask

    // One bus cycle: drive, predict, sample at negedge, advance the model
    task automatic step(input logic v, input logic s);
        int  sl;
        int  sc;
        int  idx;
        logic any;
        logic acc;
        logic err_now;
        bus.in_valid = v;
        bus.in_sop   = s;
        e_cntr = (v && s) ? 5'd0 : 5'(m_next);
        e_sc   = '0;
        e_sw   = '0;
        e_tw   = '0;
        e_tw[4:0] = e_cntr;
        for (int k = 0; k < NCM; k++) begin
            sl = (cyc - ofs[k]) & 63;
            sc = h_vld[sl] ? h_idx[sl] : 0;
            e_sc[k*5 +: 5]     = 5'(sc);
            e_sw[k]            = ((sc / dk[k]) % 2) == 1;
            e_tw[(k+1)*5 +: 5] = 5'((sc * (1 << (k + 1))) % N);
        end
        sl   = (cyc - LAT) & 63;
        e_ov = h_vld[sl];
        e_os = h_sop[sl];
`ifdef R2MDC_BITREV_OUT_EN
        e_idx = h_vld[sl] ? bitrev5(h_idx[sl]) : 5'd0;
`else
        e_idx = 5'd0;
`endif
        any = 1'b0;
        for (int d = 1; d <= LAT; d++) begin
            if (h_vld[(cyc - d) & 63]) any = 1'b1;
        end
        e_busy = (m_next != 0) || any;
        e_err  = m_err;

        @(negedge CLK);
        sample();

        acc     = 1'b0;
        err_now = 1'b0;
        idx     = 0;
        if (v && s) begin
            err_now = (m_next != 0);
            acc     = 1'b1;
            m_next  = 1;
        end else if (m_next != 0) begin
            if (v) begin
                idx    = m_next;
                acc    = 1'b1;
                m_next = (m_next + 1) % N;
            end else begin
                err_now = 1'b1;
                m_next  = 0;
            end
        end
        h_vld[cyc & 63] = acc;
        h_sop[cyc & 63] = acc && s;
        h_idx[cyc & 63] = acc ? idx : 0;
        m_err = err_now;
        cyc++;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        sample();
        n_checks++;
        if (obs_vec() !== 74'd0) begin
            n_fail++;
            $display("FAIL reset_state got=%h expected=0", obs_vec());
        end
        RSTN = 1'b1;
        @(posedge CLK);
        #1;
        model_reset();
        cyc = 0;
    endtask

    task automatic test_single_frame();
        int   first_os = -1;
        int   nov = 0;
        int   busy_fall = -1;
        logic prev_busy = 1'b0;
        logic [4:0] idx_seq [4];
        idx_seq[0] = 5'd0; idx_seq[1] = 5'd16; idx_seq[2] = 5'd8; idx_seq[3] = 5'd24;
        for (int i = 0; i < N + LAT + 8; i++) begin
            step(i < N, i == 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_outputs i=%0d got=%h expected=%h", i, obs_vec(), exp_vec());
            end
            if (i < N) begin
                n_checks++;
                if (o_cntr !== 5'(i)) begin
                    n_fail++;
                    $display("FAIL single_cntr i=%0d got=%0d expected=%0d", i, o_cntr, i);
                end
            end
            if (i == 36 || i == 37) begin
                n_checks++;
                if (o_sw[4] !== (i == 37)) begin
                    n_fail++;
                    $display("FAIL single_swap4 i=%0d got=%b expected=%b", i, o_sw[4], (i == 37));
                end
            end
`ifdef R2MDC_BITREV_OUT_EN
            if (i >= LAT && i < LAT + 4) begin
                n_checks++;
                if (o_idx !== idx_seq[i-LAT]) begin
                    n_fail++;
                    $display("FAIL single_out_idx i=%0d got=%0d expected=%0d", i, o_idx, idx_seq[i-LAT]);
                end
            end
`endif
            if (o_ov) nov++;
            if (o_os && first_os < 0) first_os = i;
            if (prev_busy && !o_busy && busy_fall < 0) busy_fall = i;
            prev_busy = o_busy;
        end
        n_checks++;
        if (first_os != LAT) begin
            n_fail++;
            $display("FAIL single_first_sop got=%0d expected=%0d", first_os, LAT);
        end
        n_checks++;
        if (nov != N) begin
            n_fail++;
            $display("FAIL single_valid_count got=%0d expected=%0d", nov, N);
        end
        n_checks++;
        if (busy_fall != LAT + N) begin
            n_fail++;
            $display("FAIL single_busy_fall got=%0d expected=%0d", busy_fall, LAT + N);
        end
    endtask

    task automatic test_back_to_back();
        int nov = 0;
        int run = 0;
        int max_run = 0;
        int nerr = 0;
        for (int i = 0; i < 3 * N + LAT + 8; i++) begin
            step(i < 3 * N, (i < 3 * N) && (i % N == 0));
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b_outputs i=%0d got=%h expected=%h", i, obs_vec(), exp_vec());
            end
            if (i < 3 * N) begin
                n_checks++;
                if (o_cntr !== 5'(i % N)) begin
                    n_fail++;
                    $display("FAIL b2b_cntr i=%0d got=%0d expected=%0d", i, o_cntr, i % N);
                end
            end
            if (o_err) nerr++;
            if (o_ov) begin
                nov++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        n_checks++;
        if (nerr != 0) begin
            n_fail++;
            $display("FAIL b2b_err got=%0d expected=0", nerr);
        end
        n_checks++;
        if (nov != 3 * N || max_run != 3 * N) begin
            n_fail++;
            $display("FAIL b2b_valid_run got=%0d/%0d expected=%0d", nov, max_run, 3 * N);
        end
    endtask

    task automatic test_gap();
        int nov = 0;
        int nerr = 0;
        for (int i = 0; i < 11 + LAT + 5; i++) begin
            step(i < 10, i == 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL gap_outputs i=%0d got=%h expected=%h", i, obs_vec(), exp_vec());
            end
            if (i == 11) begin
                n_checks++;
                if (o_err !== 1'b1 || o_cntr !== 5'd0) begin
                    n_fail++;
                    $display("FAIL gap_abort err=%b cntr=%0d expected err=1 cntr=0", o_err, o_cntr);
                end
            end
            if (o_err) nerr++;
            if (o_ov) nov++;
        end
        n_checks++;
        if (nerr != 1 || nov != 10) begin
            n_fail++;
            $display("FAIL gap_drain err_pulses=%0d valids=%0d expected 1 and 10", nerr, nov);
        end
    endtask

    task automatic test_sop_restart();
        int nov = 0;
        int nerr = 0;
        int nos = 0;
        int second_os = -1;
        for (int i = 0; i < 52 + LAT + 5; i++) begin
            step(i < 52, i == 0 || i == 20);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL restart_outputs i=%0d got=%h expected=%h", i, obs_vec(), exp_vec());
            end
            if (i == 20) begin
                n_checks++;
                if (o_cntr !== 5'd0) begin
                    n_fail++;
                    $display("FAIL restart_cntr got=%0d expected=0", o_cntr);
                end
            end
            if (o_err) nerr++;
            if (o_ov) nov++;
            if (o_os) begin
                nos++;
                if (nos == 2) second_os = i;
            end
        end
        n_checks++;
        if (nerr != 1) begin
            n_fail++;
            $display("FAIL restart_err got=%0d expected=1", nerr);
        end
        n_checks++;
        if (second_os != 20 + LAT || nov != 52) begin
            n_fail++;
            $display("FAIL restart_out second_sop=%0d valids=%0d expected %0d and 52", second_os, nov, 20 + LAT);
        end
    endtask

    task automatic test_reset_mid();
        int nov = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b1, i == 0);
        end
        bus.in_valid = 1'b1;
        bus.in_sop   = 1'b0;
        RSTN = 1'b0;
        #2;
        sample();
        n_checks++;
        if (obs_vec() !== 74'd0) begin
            n_fail++;
            $display("FAIL reset_mid_clear got=%h expected=0", obs_vec());
        end
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        model_reset();
        cyc++;
        for (int i = 0; i < LAT + 5; i++) begin
            step(1'b0, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_mid_outputs i=%0d got=%h expected=%h", i, obs_vec(), exp_vec());
            end
            if (o_ov) nov++;
        end
        n_checks++;
        if (nov != 0) begin
            n_fail++;
            $display("FAIL reset_mid_valids got=%0d expected=0", nov);
        end
    endtask

    task automatic test_random();
        logic v;
        logic s;
        for (int i = 0; i < 600 + LAT + 5; i++) begin
            if (i >= 600) begin
                v = 1'b0;
                s = 1'b0;
            end else if (m_next != 0) begin
                v = ($urandom_range(0, 15) != 0);
                s = v && ($urandom_range(0, 24) == 0);
            end else begin
                v = ($urandom_range(0, 2) == 0);
                s = ($urandom_range(0, 1) == 0);
            end
            step(v, s);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_outputs i=%0d got=%h expected=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        int acc;
        acc = 0;
        for (int k = 0; k < NCM; k++) begin
            dk[k] = N >> (k + 1);
            acc   = acc + dk[k] + 1;
            ofs[k] = acc;
        end
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gap();
        test_sop_restart();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "time limit");
    end
endmodule
